// File: rtl/snd_vram_rdslave.sv
// snd_vram_rdslave: AXI4-style read-only responder (AR/R channels) serving
// bursts out of an on-chip word RAM. A side write port lets a loader fill the
// RAM. Each RAM read lands straight in a 2-entry output skid buffer, so with
// RREADY held high the burst streams one beat per cycle.
module snd_vram_rdslave #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [31:0]       ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic              MEM_WE,
  input  logic [ADDR_W-1:0] MEM_WADDR,
  input  logic [31:0]       MEM_WDATA
);

  localparam int          DEPTH = 1 << ADDR_W;
  // Size of the decoded window in bytes; 33 bits so ADDR_W=30 still fits.
  localparam logic [32:0] SPAN  = 33'd4 << ADDR_W;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              state_q, state_d;
  logic [31:0]         mem_q [DEPTH];

  // Burst context: next word to read, reads still to issue, decode miss flag.
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [8:0]          issue_left_q, issue_left_d;
  logic                oor_q, oor_d;

  // Output skid buffer: two entries, circular pointers and an occupancy count.
  logic [31:0]         buf_data_q [2];
  logic [1:0]          buf_last_q;
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          cnt_q, cnt_d;

  logic                ar_fire;
  logic                r_fire;
  logic                rd_issue;
  logic [31:0]         ar_off;
  logic                ar_in_range;

  // Decode of the incoming burst start address.
  assign ar_off      = ARADDR - BASE_ADDR;
  assign ar_in_range = (ARADDR >= BASE_ADDR) && ({1'b0, ar_off} < SPAN);

  // Output decode: handshakes, R channel view of the buffer head, issue gate.
  always_comb begin
    ARREADY  = (state_q == S_IDLE);
    RVALID   = (cnt_q != 2'd0);
    RDATA    = buf_data_q[rd_ptr_q];
    RLAST    = RVALID && buf_last_q[rd_ptr_q];
    RRESP    = (RVALID && oor_q) ? 2'b11 : 2'b00;
    ar_fire  = ARVALID && ARREADY;
    r_fire   = RVALID && RREADY;
    // Only read when the buffer still has a free slot after this cycle's pop.
    rd_issue = (state_q == S_BURST) && (issue_left_q != 9'd0) &&
               ((cnt_q - {1'b0, r_fire}) < 2'd2);
  end

  // Next-state logic: one burst in service at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ar_fire) state_d = S_BURST;
      S_BURST: if (r_fire && RLAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Burst context and buffer occupancy next-state.
  always_comb begin
    idx_d        = idx_q;
    issue_left_d = issue_left_q;
    oor_d        = oor_q;
    if (ar_fire) begin
      idx_d        = ar_off[ADDR_W+1:2];
      issue_left_d = {1'b0, ARLEN} + 9'd1;
      oor_d        = !ar_in_range;
    end else if (rd_issue) begin
      // Word index wraps naturally at the top of the RAM.
      idx_d        = idx_q + 1'b1;
      issue_left_d = issue_left_q - 9'd1;
    end
    cnt_d = cnt_q + {1'b0, rd_issue} - {1'b0, r_fire};
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Burst context, pointers and buffer contents; reset drops any buffered beats.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      idx_q        <= '0;
      issue_left_q <= '0;
      oor_q        <= 1'b0;
      cnt_q        <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      buf_last_q   <= '0;
      for (int i = 0; i < 2; i++) buf_data_q[i] <= '0;
    end else begin
      idx_q        <= idx_d;
      issue_left_q <= issue_left_d;
      oor_q        <= oor_d;
      cnt_q        <= cnt_d;
      if (rd_issue) begin
        // Registered RAM read lands directly in the free buffer slot.
        buf_data_q[wr_ptr_q] <= oor_q ? 32'd0 : mem_q[idx_q];
        buf_last_q[wr_ptr_q] <= (issue_left_q == 9'd1);
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (r_fire) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Loader write port; active regardless of reset so RAM contents survive it.
  always_ff @(posedge ACLK) begin
    if (MEM_WE) mem_q[MEM_WADDR] <= MEM_WDATA;
  end

endmodule
